// File: rtl/uclk_ctrl.sv
// -----------------------------------------------------------------------------
// uclk_ctrl -- micro-cycle controller for the KS-10 microsequencer.
//
// Produces the single clock enable (clken) shared by the microsequencer, the
// CROM and the call/return stack. Implements console run / halt / single
// micro-step, a CROM-address breakpoint, a memory-wait stall and an optional
// micro-cycle counter.
//
// Optional feature macro: UCLK_CYCLE_COUNT_EN
//   defined   -> cycleCNT counts completed micro-cycles; cmdCLR clears it
//   undefined -> counter omitted, cycleCNT is constant 0, cmdCLR is ignored
//
// Parameters:
//   CLKDIV  system clocks per micro-cycle tick (>= 1)
//   RUNRST  state after reset: 0 = HALT, 1 = RUN
//   CNTW    width of the micro-cycle counter
//
// Ports:
//   clk       in   system clock
//   rst       in   asynchronous active-low reset
//   cmdRUN    in   pulse: enter RUN
//   cmdHALT   in   pulse: enter HALT
//   cmdSTEP   in   pulse: execute exactly one micro-cycle
//   cmdCLR    in   pulse: clear cycle counter
//   brkEN     in   breakpoint enable
//   brkADDR   in   breakpoint CROM address (12 bits)
//   addr      in   CROM address presented this cycle (12 bits)
//   memWAIT   in   memory/bus stall, blocks the micro-cycle
//   clken     out  micro-cycle enable to the CPU
//   halted    out  1 in HALT or BREAK
//   brkHIT    out  sticky breakpoint indicator
//   stepDONE  out  one-clk pulse after a single step completes
//   cycleCNT  out  completed micro-cycles (CNTW bits)
// -----------------------------------------------------------------------------
module uclk_ctrl #(
  parameter int CLKDIV = 4,
  parameter bit RUNRST = 1'b0,
  parameter int CNTW   = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cmdRUN,
  input  logic            cmdHALT,
  input  logic            cmdSTEP,
  input  logic            cmdCLR,
  input  logic            brkEN,
  input  logic [11:0]     brkADDR,
  input  logic [11:0]     addr,
  input  logic            memWAIT,
  output logic            clken,
  output logic            halted,
  output logic            brkHIT,
  output logic            stepDONE,
  output logic [CNTW-1:0] cycleCNT
);

  typedef enum logic [1:0] {
    ST_HALT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STEP  = 2'd2,
    ST_BREAK = 2'd3
  } state_e;

  localparam state_e RST_STATE = RUNRST ? ST_RUN : ST_HALT;

  // Prescaler width kept at least 1 bit so CLKDIV = 1 still elaborates.
  localparam int          PW     = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam logic [PW-1:0] PS_MAX = PW'(CLKDIV - 1);
  localparam logic [PW-1:0] PS_ONE = PW'(1);

  logic [PW-1:0] ps_q, ps_d;
  state_e        state_q;
  logic          skip_q;
  logic          brk_hit_q;
  logic          step_done_q;

  logic          tick_s;
  logic          bpmatch_s;
  logic          want_s;

  assign tick_s = (ps_q == PS_MAX);

  // The breakpoint only fires in RUN, and not on the first micro-cycle after a
  // resume, so the instruction that broke gets to execute once.
  assign bpmatch_s = brkEN & (addr == brkADDR) & (state_q == ST_RUN) & ~skip_q;

  assign want_s = tick_s & ((state_q == ST_RUN) | (state_q == ST_STEP))
                  & ~memWAIT & ~bpmatch_s;

  // Gated by rst so no enable leaks out while reset is held (matters for
  // CLKDIV = 1 with RUNRST = 1, where every clock is a tick).
  assign clken    = want_s & rst;
  assign halted   = (state_q == ST_HALT) | (state_q == ST_BREAK);
  assign brkHIT   = brk_hit_q;
  assign stepDONE = step_done_q;

  // Prescaler next value: free-running 0..CLKDIV-1.
  always_comb begin
    ps_d = ps_q;
    if (tick_s) begin
      ps_d = '0;
    end else begin
      ps_d = ps_q + PS_ONE;
    end
  end

  // Prescaler register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ps_q <= '0;
    end else begin
      ps_q <= ps_d;
    end
  end

  // Control FSM with its registered flags. Command priority HALT > RUN > STEP.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RST_STATE;
      skip_q      <= 1'b0;
      brk_hit_q   <= 1'b0;
      step_done_q <= 1'b0;
    end else begin
      step_done_q <= 1'b0;
      case (state_q)
        ST_HALT: begin
          if (cmdHALT) begin
            state_q <= ST_HALT;
          end else if (cmdRUN) begin
            state_q <= ST_RUN;
            skip_q  <= 1'b1;
          end else if (cmdSTEP) begin
            state_q <= ST_STEP;
          end else begin
            state_q <= ST_HALT;
          end
        end
        ST_RUN: begin
          if (want_s) begin
            skip_q <= 1'b0;
          end
          if (cmdHALT) begin
            state_q <= ST_HALT;
          end else if (tick_s & bpmatch_s & ~memWAIT) begin
            state_q   <= ST_BREAK;
            brk_hit_q <= 1'b1;
          end else begin
            state_q <= ST_RUN;
          end
        end
        ST_STEP: begin
          // Once the enable has gone out the step is complete; a HALT in the
          // same clock cannot take it back.
          if (want_s) begin
            state_q     <= ST_HALT;
            step_done_q <= 1'b1;
          end else if (cmdHALT) begin
            state_q <= ST_HALT;
          end else if (cmdRUN) begin
            state_q <= ST_RUN;
            skip_q  <= 1'b1;
          end else begin
            state_q <= ST_STEP;
          end
        end
        ST_BREAK: begin
          if (cmdHALT) begin
            state_q <= ST_HALT;
          end else if (cmdRUN) begin
            state_q   <= ST_RUN;
            skip_q    <= 1'b1;
            brk_hit_q <= 1'b0;
          end else if (cmdSTEP) begin
            state_q   <= ST_STEP;
            brk_hit_q <= 1'b0;
          end else begin
            state_q <= ST_BREAK;
          end
        end
        default: begin
          state_q <= RST_STATE;
        end
      endcase
    end
  end

`ifdef UCLK_CYCLE_COUNT_EN
  localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);

  logic [CNTW-1:0] cnt_q, cnt_d;

  // Counter next value: clear wins over a coincident micro-cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (cmdCLR) begin
      cnt_d = '0;
    end else if (clken) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Micro-cycle counter register; wraps naturally at 2^CNTW.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cycleCNT = cnt_q;
`else
  logic unused_cmdclr_s;

  assign unused_cmdclr_s = cmdCLR;
  assign cycleCNT        = '0;
`endif

endmodule

// File: tb/tb_uclk_ctrl.sv
`timescale 1ns/1ps
module tb_uclk_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmdRUN, cmdHALT, cmdSTEP, cmdCLR;
  logic        brkEN;
  logic [11:0] brkADDR, addr;
  logic        memWAIT;
  logic        clken, halted, brkHIT, stepDONE;
  logic [3:0]  cycleCNT;

  logic        clken1, halted1, brkHIT1, stepDONE1;
  logic [31:0] cycleCNT1;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int pulses1 = 0;
  int dones = 0;
  int kc = 0;
  int ks [0:255];

  always #5 clk = ~clk;

  uclk_ctrl #(.CLKDIV(4), .RUNRST(1'b0), .CNTW(4)) u0 (
    .clk(clk), .rst(rst), .cmdRUN(cmdRUN), .cmdHALT(cmdHALT), .cmdSTEP(cmdSTEP),
    .cmdCLR(cmdCLR), .brkEN(brkEN), .brkADDR(brkADDR), .addr(addr),
    .memWAIT(memWAIT), .clken(clken), .halted(halted), .brkHIT(brkHIT),
    .stepDONE(stepDONE), .cycleCNT(cycleCNT)
  );

  uclk_ctrl #(.CLKDIV(1), .RUNRST(1'b1), .CNTW(32)) u1 (
    .clk(clk), .rst(rst), .cmdRUN(1'b0), .cmdHALT(1'b0), .cmdSTEP(1'b0),
    .cmdCLR(1'b0), .brkEN(1'b0), .brkADDR(12'd0), .addr(12'd0),
    .memWAIT(1'b0), .clken(clken1), .halted(halted1), .brkHIT(brkHIT1),
    .stepDONE(stepDONE1), .cycleCNT(cycleCNT1)
  );

  // Clock index since reset release; prescaler of u0 equals kc % 4.
  always @(posedge clk or negedge rst) begin
    if (!rst) kc <= 0;
    else      kc <= kc + 1;
  end

  // Count enables and step-done pulses mid-cycle, recording when each enable fell.
  always @(negedge clk) begin
    if (rst) begin
      if (clken) begin
        ks[pulses] <= kc;
        pulses     <= pulses + 1;
      end
      if (clken1)   pulses1 <= pulses1 + 1;
      if (stepDONE) dones   <= dones + 1;
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] cexp(input int v);
`ifdef UCLK_CYCLE_COUNT_EN
    return 32'(v);
`else
    return 32'd0;
`endif
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int p0, d0, drop_k, exp_k;
    bit found;

    rst = 1'b0; cmdRUN = 1'b0; cmdHALT = 1'b0; cmdSTEP = 1'b0; cmdCLR = 1'b0;
    brkEN = 1'b0; brkADDR = 12'o0100; addr = 12'o0077; memWAIT = 1'b0;

    // Reset state
    cyc(3);
    #1;
    chk("rst_clken", {31'd0, clken}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd1);
    chk("rst_brkhit", {31'd0, brkHIT}, 32'd0);
    chk("rst_stepdone", {31'd0, stepDONE}, 32'd0);
    chk("rst_cnt", {28'd0, cycleCNT}, 32'd0);
    chk("rst_halted_runrst", {31'd0, halted1}, 32'd0);
    chk("rst_clken_runrst", {31'd0, clken1}, 32'd0);
    rst = 1'b1;

    // Idle in HALT for 20 clocks; the RUNRST/CLKDIV=1 instance runs every clk
    cyc(20);
    chk("idle_pulses", 32'(pulses), 32'd0);
    chk("idle_halted", {31'd0, halted}, 32'd1);
    chk("idle_cnt", {28'd0, cycleCNT}, 32'd0);
    chk("div1_pulses", 32'(pulses1), 32'd20);
    chk("div1_cnt", cycleCNT1, cexp(20));
    chk("div1_halted", {31'd0, halted1}, 32'd0);

    // RUN for 40 clocks: one enable every 4 clocks
    cmdRUN = 1'b1; cyc(1); cmdRUN = 1'b0;
    p0 = pulses;
    cyc(40);
    chk("run_pulses", 32'(pulses - p0), 32'd10);
    chk("run_halted", {31'd0, halted}, 32'd0);
    chk("run_cnt", {28'd0, cycleCNT}, cexp(10));

    // Memory wait for 9 clocks, then resume on the next tick
    memWAIT = 1'b1;
    p0 = pulses;
    cyc(9);
    chk("wait_pulses", 32'(pulses - p0), 32'd0);
    memWAIT = 1'b0;
    drop_k = kc;
    exp_k = drop_k;
    while ((exp_k % 4) != 3) exp_k++;
    cyc(8);
    chk("wait_resume_pulses", 32'(pulses - p0), 32'd2);
    chk("wait_first_tick", 32'(ks[p0]), 32'(exp_k));
    chk("wait_cnt", {28'd0, cycleCNT}, cexp(12));

    // Breakpoint at o0100
    brkEN = 1'b1; addr = 12'o0100;
    p0 = pulses;
    cyc(8);
    chk("bp_nopulse", 32'(pulses - p0), 32'd0);
    chk("bp_halted", {31'd0, halted}, 32'd1);
    chk("bp_hit", {31'd0, brkHIT}, 32'd1);
    chk("bp_clken", {31'd0, clken}, 32'd0);

    // Resume: breakpoint instruction executes once, then run continues
    cmdRUN = 1'b1; cyc(1); cmdRUN = 1'b0;
    chk("bp_hit_clr", {31'd0, brkHIT}, 32'd0);
    chk("bp_resume_halted", {31'd0, halted}, 32'd0);
    p0 = pulses;
    cyc(4);
    chk("bp_once", 32'(pulses - p0), 32'd1);
    addr = 12'o0101;
    cyc(8);
    chk("bp_cont", 32'(pulses - p0), 32'd3);
    chk("bp_cont_halted", {31'd0, halted}, 32'd0);

    // Hitting the breakpoint address again breaks again
    addr = 12'o0100;
    p0 = pulses;
    cyc(8);
    chk("bp_again_nopulse", 32'(pulses - p0), 32'd0);
    chk("bp_again_hit", {31'd0, brkHIT}, 32'd1);
    chk("bp_again_halted", {31'd0, halted}, 32'd1);
    chk("bp_cnt", {28'd0, cycleCNT}, cexp(15));

    // HALT from BREAK keeps brkHIT sticky
    cmdHALT = 1'b1; cyc(1); cmdHALT = 1'b0;
    chk("halt_sticky", {31'd0, brkHIT}, 32'd1);
    chk("halt_halted", {31'd0, halted}, 32'd1);
    brkEN = 1'b0; addr = 12'o0077;

    // Single step from HALT
    cmdSTEP = 1'b1; cyc(1); cmdSTEP = 1'b0;
    p0 = pulses; d0 = dones; found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      cyc(1);
      if (pulses != p0) found = 1'b1;
    end
    chk("step_found", {31'd0, found}, 32'd1);
    chk("step_one", 32'(pulses - p0), 32'd1);
    chk("step_done", {31'd0, stepDONE}, 32'd1);
    chk("step_halted", {31'd0, halted}, 32'd1);
    cyc(1);
    chk("step_done_end", {31'd0, stepDONE}, 32'd0);
    cyc(12);
    chk("step_only", 32'(pulses - p0), 32'd1);
    chk("step_done_cnt", 32'(dones - d0), 32'd1);
    chk("step_cnt_wrap", {28'd0, cycleCNT}, cexp(0));

    // STEP and HALT together: HALT wins
    cmdSTEP = 1'b1; cmdHALT = 1'b1; cyc(1); cmdSTEP = 1'b0; cmdHALT = 1'b0;
    p0 = pulses; d0 = dones;
    cyc(12);
    chk("sh_nopulse", 32'(pulses - p0), 32'd0);
    chk("sh_halted", {31'd0, halted}, 32'd1);
    chk("sh_nodone", 32'(dones - d0), 32'd0);

    // 17 micro-cycles on a 4-bit counter starting from 0 -> 1
    cmdRUN = 1'b1; cyc(1); cmdRUN = 1'b0;
    p0 = pulses; found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      cyc(1);
      if ((pulses - p0) == 17) found = 1'b1;
    end
    cmdHALT = 1'b1; cyc(1); cmdHALT = 1'b0;
    chk("cnt17_found", {31'd0, found}, 32'd1);
    chk("cnt17_pulses", 32'(pulses - p0), 32'd17);
    chk("cnt17_wrap", {28'd0, cycleCNT}, cexp(1));

    // Clear alone
    cmdCLR = 1'b1; cyc(1); cmdCLR = 1'b0;
    chk("clr_alone", {28'd0, cycleCNT}, 32'd0);

    // Clear coincident with an enable
    cmdRUN = 1'b1; cyc(1); cmdRUN = 1'b0;
    cyc(4);
    chk("clr_pre_cnt", {28'd0, cycleCNT}, cexp(1));
    for (int i = 0; i < 4 && (kc % 4) != 3; i++) cyc(1);
    cmdCLR = 1'b1;
    #1;
    chk("clr_coinc_clken", {31'd0, clken}, 32'd1);
    cyc(1);
    cmdCLR = 1'b0;
    chk("clr_coinc_cnt", {28'd0, cycleCNT}, 32'd0);
    cmdHALT = 1'b1; cyc(1); cmdHALT = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
